fft_bitrev_reorder: RTL and testbench

//  Downstream of the radix-2 FFT core (fft_3_8 and wider variants). Accepts the

---
 rtl/fft_bitrev_reorder.sv | 218 +++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer for the radix-2 FFT output.
// Two-bank ping-pong RAM: the writer scatters each frame into one bank at
// bit-reversed addresses while the reader streams the other bank out linearly.
module fft_bitrev_reorder #(
  parameter int LOG2N = 3,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rstx,
  input  logic            clear,
  input  logic            din_valid,
  input  logic            din_sop,
  input  logic [2*DW-1:0] din,
  output logic            dout_valid,
  output logic            dout_sop,
  output logic            dout_eop,
  output logic [2*DW-1:0] dout,
  output logic            err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  typedef enum logic {W_IDLE, W_FILL}  wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  wstate_t          wstate_q, wstate_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  rstate_t          rstate_q, rstate_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  logic             err_q, err_d;
  logic             rvld_q, rvld_d, rsop_q, rsop_d, reop_q, reop_d;
  logic             dout_valid_q, dout_valid_d, dout_sop_q, dout_sop_d;
  logic             dout_eop_q, dout_eop_d;
  logic [2*DW-1:0]  dout_q, dout_d;

  logic             we, re, set_full, clr_full;
  logic [LOG2N-1:0] wr_idx, rd_idx;
  logic [2*DW-1:0]  mem [0:2*N-1];
  logic [2*DW-1:0]  ram_rdata;

  // Writer: count samples of the current frame and scatter them bit-reversed
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    err_d    = err_q;
    we       = 1'b0;
    wr_idx   = '0;
    set_full = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (din_valid && din_sop) begin
          we       = 1'b1;
          wcnt_d   = ONE;
          wstate_d = W_FILL;
        end
      end
      default: begin
        if (din_valid) begin
          we = 1'b1;
          if (din_sop) begin
            // restart the frame in the same bank; the partial frame is lost
            err_d  = 1'b1;
            wcnt_d = ONE;
          end else begin
            wr_idx = wcnt_q;
            if (wcnt_q == LAST) begin
              set_full = 1'b1;
              wbank_d  = ~wbank_q;
              wcnt_d   = '0;
              wstate_d = W_IDLE;
            end else begin
              wcnt_d = wcnt_q + ONE;
            end
          end
        end
      end
    endcase
    if (clear) begin
      wstate_d = W_IDLE;
      wcnt_d   = '0;
      wbank_d  = 1'b0;
      err_d    = 1'b0;
      we       = 1'b0;
      set_full = 1'b0;
    end
  end

  // Reader: drain a full bank linearly; idle state issues the first read so
  // back-to-back banks stream without a gap
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    re       = 1'b0;
    rd_idx   = '0;
    clr_full = 1'b0;
    rsop_d   = 1'b0;
    reop_d   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          re       = 1'b1;
          rsop_d   = 1'b1;
          rcnt_d   = ONE;
          rstate_d = R_DRAIN;
        end
      end
      default: begin
        re     = 1'b1;
        rd_idx = rcnt_q;
        if (rcnt_q == LAST) begin
          reop_d   = 1'b1;
          clr_full = 1'b1;
          rbank_d  = ~rbank_q;
          rcnt_d   = '0;
          rstate_d = R_IDLE;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end
    endcase
    rvld_d = re;
    if (clear) begin
      rstate_d = R_IDLE;
      rcnt_d   = '0;
      rbank_d  = 1'b0;
      re       = 1'b0;
      clr_full = 1'b0;
      rvld_d   = 1'b0;
      rsop_d   = 1'b0;
      reop_d   = 1'b0;
    end
  end

  // Bank occupancy: writer sets and reader frees, never on the same bank
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rbank_q] = 1'b0;
    if (set_full) full_d[wbank_q] = 1'b1;
    if (clear)    full_d = 2'b00;
  end

  // Output register: data holds between bursts, markers only while valid
  always_comb begin
    dout_valid_d = rvld_q;
    dout_sop_d   = rsop_q;
    dout_eop_d   = reop_q;
    dout_d       = rvld_q ? ram_rdata : dout_q;
    if (clear) begin
      dout_valid_d = 1'b0;
      dout_sop_d   = 1'b0;
      dout_eop_d   = 1'b0;
      dout_d       = '0;
    end
  end

  // Ping-pong RAM with synchronous read; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[{wbank_q, bitrev(wr_idx)}] <= din;
    if (re) ram_rdata <= mem[{rbank_q, rd_idx}];
  end

  // Control and output state registers
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      wstate_q     <= W_IDLE;
      wcnt_q       <= '0;
      wbank_q      <= 1'b0;
      rstate_q     <= R_IDLE;
      rcnt_q       <= '0;
      rbank_q      <= 1'b0;
      full_q       <= 2'b00;
      err_q        <= 1'b0;
      rvld_q       <= 1'b0;
      rsop_q       <= 1'b0;
      reop_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
      dout_q       <= '0;
    end else begin
      wstate_q     <= wstate_d;
      wcnt_q       <= wcnt_d;
      wbank_q      <= wbank_d;
      rstate_q     <= rstate_d;
      rcnt_q       <= rcnt_d;
      rbank_q      <= rbank_d;
      full_q       <= full_d;
      err_q        <= err_d;
      rvld_q       <= rvld_d;
      rsop_q       <= rsop_d;
      reop_q       <= reop_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_eop_q   <= dout_eop_d;
      dout_q       <= dout_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sop   = dout_sop_q;
  assign dout_eop   = dout_eop_q;
  assign dout       = dout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: literal frame vectors, directed corner
// sequences, and a randomized stream scored against a frame-level model.
module tb_fft_bitrev_reorder;

  localparam int LOG2N = 3;
  localparam int DW    = 8;
  localparam int N     = 8;

  logic clk = 1'b0, rstx = 1'b0, clear = 1'b0, din_valid = 1'b0, din_sop = 1'b0;
  logic [2*DW-1:0] din = '0;
  logic dout_valid, dout_sop, dout_eop, err;
  logic [2*DW-1:0] dout;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rstx(rstx), .clear(clear), .din_valid(din_valid),
    .din_sop(din_sop), .din(din), .dout_valid(dout_valid), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout(dout), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef struct {
    logic [2*DW-1:0] d;
    logic            sop;
    logic            eop;
  } oexp_t;

  oexp_t           exp_q [int];
  logic [2*DW-1:0] frame [$];
  int              busy_end = 0;
  logic            m_err = 1'b0;
  logic [2*DW-1:0] m_last = '0;
  bit              mon_en = 1'b0;

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // Each edge: collect frames; a finished frame is emitted in natural order
  // starting two edges later, or right after the previous burst ends.
  always @(posedge clk) begin
    int ks[$];
    int start;
    oexp_t e;
    cyc++;
    if (!rstx || clear) begin
      frame.delete();
      m_err    = 1'b0;
      busy_end = 0;
      m_last   = '0;
      foreach (exp_q[key]) if (key >= cyc) ks.push_back(key);
      foreach (ks[i]) exp_q.delete(ks[i]);
    end else if (din_valid) begin
      if (din_sop) begin
        if (frame.size() > 0) m_err = 1'b1;
        frame.delete();
        frame.push_back(din);
      end else if (frame.size() > 0) begin
        frame.push_back(din);
      end
      if (frame.size() == N) begin
        start = (cyc + 2 > busy_end + 1) ? cyc + 2 : busy_end + 1;
        for (int j = 0; j < N; j++) begin
          e.d   = frame[brev(j)];
          e.sop = (j == 0);
          e.eop = (j == N - 1);
          exp_q[start + j] = e;
        end
        busy_end = start + N - 1;
        frame.delete();
      end
    end
  end

  // Every cycle: compare the output port against the model's schedule
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.exists(cyc)) begin
        chk("mon_out", 32'({dout_valid, dout_sop, dout_eop, dout}),
            32'({1'b1, exp_q[cyc].sop, exp_q[cyc].eop, exp_q[cyc].d}));
        m_last = exp_q[cyc].d;
        exp_q.delete(cyc);
      end else begin
        chk("mon_idle", 32'({dout_valid, dout_sop, dout_eop, dout}),
            32'({3'b000, m_last}));
      end
      chk("mon_err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic s, input logic [2*DW-1:0] d, input logic c);
    @(negedge clk);
    din_valid = v;
    din_sop   = s;
    din       = d;
    clear     = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic send_rand_frame();
    for (int k = 0; k < N; k++) drive(1'b1, k == 0, 16'($urandom), 1'b0);
  endtask

  int cur_run = 0, max_run = 0, sop_cnt = 0, vld_cnt = 0;

  task automatic track();
    if (dout_valid) begin
      cur_run++;
      vld_cnt++;
      if (cur_run > max_run) max_run = cur_run;
      if (dout_sop) sop_cnt++;
    end else begin
      cur_run = 0;
    end
  endtask

  // ---------------- literal vectors ----------------
  typedef struct {
    logic [7:0] re  [8];
    logic [7:0] im  [8];
    bit         gap;
    logic [7:0] ere [8];
    logic [7:0] eim [8];
  } vec_t;

  vec_t vt [3];

  initial begin
    int kk;
    int r;
    logic v, s, c;

    vt[0].re  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    vt[0].im  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0].gap = 1'b0;
    vt[0].ere = '{8'h00, 8'h04, 8'h02, 8'h06, 8'h01, 8'h05, 8'h03, 8'h07};
    vt[0].eim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[1].re  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    vt[1].im  = '{8'hF0, 8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hEB, 8'hEA, 8'hE9};
    vt[1].gap = 1'b0;
    vt[1].ere = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
    vt[1].eim = '{8'hF0, 8'hEC, 8'hEE, 8'hEA, 8'hEF, 8'hEB, 8'hED, 8'hE9};
    vt[2].re  = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01, 8'hFE, 8'h55, 8'hAA};
    vt[2].im  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    vt[2].gap = 1'b1;
    vt[2].ere = '{8'hFF, 8'h01, 8'h7F, 8'h55, 8'h00, 8'hFE, 8'h80, 8'hAA};
    vt[2].eim = '{8'h00, 8'h04, 8'h02, 8'h06, 8'h01, 8'h05, 8'h03, 8'h07};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out", 32'({dout_valid, dout_sop, dout_eop, dout, err}), 32'd0);
    mon_en = 1'b1;
    #2 rstx = 1'b1;
    idle(3);

    // table: single frames, contiguous and gapped, exact latency
    for (int v_i = 0; v_i < 3; v_i++) begin
      for (int k = 0; k < N; k++) begin
        drive(1'b1, k == 0, {vt[v_i].im[k], vt[v_i].re[k]}, 1'b0);
        if (vt[v_i].gap && k < N - 1) drive(1'b0, 1'b1, 16'($urandom), 1'b0);
      end
      idle(1);
      chk("tbl_lat1", 32'(dout_valid), 32'd0);
      idle(1);
      chk("tbl_lat2", 32'(dout_valid), 32'd0);
      for (int j = 0; j < N; j++) begin
        idle(1);
        chk("tbl_bin", 32'({dout_valid, dout_sop, dout_eop, dout}),
            32'({1'b1, j == 0, j == N - 1, vt[v_i].eim[j], vt[v_i].ere[j]}));
      end
      idle(1);
      chk("tbl_after", 32'({dout_valid, dout}),
          32'({1'b0, vt[v_i].eim[N-1], vt[v_i].ere[N-1]}));
      idle(2);
    end

    // three frames back to back: one 24-cycle burst, three sops
    cur_run = 0; max_run = 0; sop_cnt = 0; vld_cnt = 0;
    for (int i = 0; i < 3 * N; i++) begin
      drive(1'b1, (i % N) == 0, 16'($urandom), 1'b0);
      track();
    end
    for (int i = 0; i < 20; i++) begin
      idle(1);
      track();
    end
    chk("b2b_run", 32'(max_run), 32'd24);
    chk("b2b_sops", 32'(sop_cnt), 32'd3);

    // early sop: err sticks, only the second frame comes out
    vld_cnt = 0;
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 16'($urandom), 1'b0);
    chk("early_err0", 32'(err), 32'd0);
    send_rand_frame();
    for (int i = 0; i < 16; i++) begin
      idle(1);
      track();
    end
    chk("early_err1", 32'(err), 32'd1);
    chk("early_cnt", 32'(vld_cnt), 32'd8);

    // clear during bin 3 of a drain
    send_rand_frame();
    idle(6);
    chk("clr_bin3", 32'({dout_valid, dout_sop, dout_eop}), 32'b100);
    clear = 1'b1;
    idle(1);
    chk("clr_vld", 32'({dout_valid, dout_sop, dout_eop, dout}), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    vld_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      idle(1);
      track();
    end
    chk("clr_quiet", 32'(vld_cnt), 32'd0);
    send_rand_frame();
    idle(12);

    // async reset mid-drain after setting err
    for (int k = 0; k < 3; k++) drive(1'b1, k == 0, 16'($urandom), 1'b0);
    send_rand_frame();
    idle(4);
    chk("rst_pre_err", 32'(err), 32'd1);
    #2 rstx = 1'b0;
    #1 chk("rst_async", 32'({dout_valid, dout_sop, dout_eop, dout, err}), 32'd0);
    idle(2);
    #2 rstx = 1'b1;
    idle(12);
    chk("rst_err_after", 32'(err), 32'd0);

    // randomized stream against the model
    kk = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      v = (r < 75);
      c = ($urandom_range(0, 299) == 0);
      if (kk == 0) s = ($urandom_range(0, 7) != 0);
      else         s = ($urandom_range(0, 59) == 0);
      drive(v, s, 16'($urandom), c);
      if (c) kk = 0;
      else if (v) begin
        if (s) kk = 1;
        else if (kk > 0) kk = (kk + 1) % N;
      end
    end
    idle(30);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
